// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared mode encodings and arithmetic helpers for the vector MAC
package mac_pkg;

    localparam logic [1:0] MODE_EXT   = 2'b00;
    localparam logic [1:0] MODE_ACC   = 2'b01;
    localparam logic [1:0] MODE_START = 2'b10;

    // Lossless width of a sum of `lanes` products of two din-bit operands
    function automatic int psum_width(input int din, input int lanes);
        return 2 * din + $clog2(lanes) + 1;
    endfunction

    function automatic longint range_hi(input int ow, input bit sgn);
        return sgn ? (longint'(1) <<< (ow - 1)) - longint'(1)
                   : (longint'(1) <<< ow) - longint'(1);
    endfunction

    function automatic longint range_lo(input int ow, input bit sgn);
        return sgn ? -(longint'(1) <<< (ow - 1)) : longint'(0);
    endfunction

    function automatic logic out_of_range(input longint full, input int ow, input bit sgn);
        return (full > range_hi(ow, sgn)) || (full < range_lo(ow, sgn));
    endfunction

    // Clamp to the output range when saturating; otherwise pass through so
    // the caller's truncation keeps the low ow bits (wrap)
    function automatic longint sat_wrap(input longint full, input int ow, input bit sgn,
                                        input bit sat);
        if (sat && (full > range_hi(ow, sgn))) return range_hi(ow, sgn);
        if (sat && (full < range_lo(ow, sgn))) return range_lo(ow, sgn);
        return full;
    endfunction

endpackage

// File: rtl/mac_add_tree.sv
// rtl/mac_add_tree.sv - registered reduction of packed lane products, latency 1
module mac_add_tree
    import mac_pkg::*;
#(
    parameter int ProdWidth = 16,
    parameter int Lanes     = 4,
    parameter int SumWidth  = psum_width(ProdWidth / 2, Lanes),
    parameter int Signed    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en_i,
    input  logic [Lanes*ProdWidth-1:0] prod_i,
    output logic [SumWidth-1:0]        sum_o
);

    localparam bit Sgn = (Signed != 0);

    logic [SumWidth-1:0]  sum_d;
    logic [SumWidth-1:0]  sum_q;
    logic [ProdWidth-1:0] p;

    // Extend every lane product to the full sum width and add them up
    always_comb begin
        sum_d = '0;
        p     = '0;
        for (int k = 0; k < Lanes; k++) begin
            p     = prod_i[k*ProdWidth +: ProdWidth];
            sum_d = sum_d + {{(SumWidth - ProdWidth){Sgn && p[ProdWidth-1]}}, p};
        end
    end

    // Product-sum register; holds while the pipeline is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mac_vec_pipeline.sv
// rtl/mac_vec_pipeline.sv - 3-stage Lanes-wide dot product plus selectable partial sum
module mac_vec_pipeline
    import mac_pkg::*;
#(
    parameter int DataInWidth  = 8,
    parameter int DataOutWidth = 16,
    parameter int Lanes        = 4,
    parameter int Signed       = 1,
    parameter int Saturate     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Stall,
    input  logic                         NOPIn,
    input  logic [1:0]                   Mode,
    input  logic [Lanes*DataInWidth-1:0] W_Data,
    input  logic [Lanes*DataInWidth-1:0] I_Data,
    input  logic [DataOutWidth-1:0]      O_Data,
    output logic                         NOPOut,
    output logic [DataOutWidth-1:0]      DataOut,
    output logic                         OvfOut
);

    localparam int PW  = 2 * DataInWidth;
    localparam int SW  = psum_width(DataInWidth, Lanes);
    localparam int FW  = ((SW > DataOutWidth) ? SW : DataOutWidth) + 1;
    localparam bit Sgn = (Signed != 0);
    localparam bit Sat = (Saturate != 0);

    logic                    en;
    logic [Lanes*PW-1:0]     prod_d, prod_q;
    logic [DataOutWidth-1:0] addend1_q, addend2_q;
    logic [1:0]              mode1_q, mode2_q;
    logic                    v1_q, v2_q;
    logic [SW-1:0]           sum2;
    logic [PW-1:0]           wx, ix;
    logic [DataOutWidth-1:0] addend_sel;
    logic [FW-1:0]           full;
    longint                  full64;
    logic [DataOutWidth-1:0] dout_d, dout_q;
    logic                    ovf_d, ovf_q, nop_q;

    assign en = !Stall;

    // Per-lane products, operands extended to product width first
    always_comb begin
        prod_d = '0;
        wx     = '0;
        ix     = '0;
        for (int k = 0; k < Lanes; k++) begin
            wx = {{(PW - DataInWidth){Sgn && W_Data[k*DataInWidth + DataInWidth - 1]}},
                  W_Data[k*DataInWidth +: DataInWidth]};
            ix = {{(PW - DataInWidth){Sgn && I_Data[k*DataInWidth + DataInWidth - 1]}},
                  I_Data[k*DataInWidth +: DataInWidth]};
            prod_d[k*PW +: PW] = wx * ix;
        end
    end

    // S1 and the S2 side-band registers travelling alongside the add tree
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q    <= '0;
            addend1_q <= '0;
            mode1_q   <= MODE_EXT;
            v1_q      <= 1'b0;
            addend2_q <= '0;
            mode2_q   <= MODE_EXT;
            v2_q      <= 1'b0;
        end else if (en) begin
            prod_q    <= prod_d;
            addend1_q <= O_Data;
            mode1_q   <= Mode;
            v1_q      <= !NOPIn;
            addend2_q <= addend1_q;
            mode2_q   <= mode1_q;
            v2_q      <= v1_q;
        end
    end

    mac_add_tree #(
        .ProdWidth (PW),
        .Lanes     (Lanes),
        .SumWidth  (SW),
        .Signed    (Signed)
    ) u_add_tree (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en),
        .prod_i (prod_q),
        .sum_o  (sum2)
    );

    // S3 addend select, full-precision add, then saturate or wrap
    always_comb begin
        case (mode2_q)
            MODE_ACC:   addend_sel = dout_q;
            MODE_START: addend_sel = '0;
            default:    addend_sel = addend2_q;
        endcase
        full   = {{(FW - SW){Sgn && sum2[SW-1]}}, sum2}
               + {{(FW - DataOutWidth){Sgn && addend_sel[DataOutWidth-1]}}, addend_sel};
        full64 = {{(64 - FW){Sgn && full[FW-1]}}, full};
        dout_d = DataOutWidth'(sat_wrap(full64, DataOutWidth, Sgn, Sat));
        ovf_d  = out_of_range(full64, DataOutWidth, Sgn);
    end

    // Output stage; bubbles leave the result and flag untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
            ovf_q  <= 1'b0;
            nop_q  <= 1'b1;
        end else if (en) begin
            if (v2_q) begin
                dout_q <= dout_d;
                ovf_q  <= ovf_d;
                nop_q  <= 1'b0;
            end else begin
                nop_q  <= 1'b1;
            end
        end
    end

    assign DataOut = dout_q;
    assign OvfOut  = ovf_q;
    assign NOPOut  = nop_q;

endmodule

// File: tb/tb_mac_vec_pipeline.sv
// tb/tb_mac_vec_pipeline.sv - scoreboard bench for signed-sat, signed-wrap and unsigned-sat builds
module tb_mac_vec_pipeline;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        NOPIn = 1'b1;
    logic [1:0]  Mode = 2'b00;
    logic [31:0] W_Data = '0;
    logic [31:0] I_Data = '0;
    logic [15:0] O_Data = '0;

    logic        nop_s, nop_w, nop_u;
    logic        ov_s, ov_w, ov_u;
    logic [15:0] d_s, d_w, d_u;

    // config c: 0 signed+sat, 1 signed+wrap, 2 unsigned+sat
    localparam bit [2:0] CFG_SGN = 3'b011;
    localparam bit [2:0] CFG_SAT = 3'b101;

    typedef struct packed {
        logic        nop;
        logic [47:0] d;
        logic [2:0]  ov;
    } exp_t;

    exp_t        sbq[$];
    exp_t        last_e;
    logic [15:0] m_dout [3];
    logic        m_ovf  [3];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mac_vec_pipeline #(.Signed(1), .Saturate(1)) u_dut (
        .clk(clk), .reset(reset), .Stall(Stall), .NOPIn(NOPIn), .Mode(Mode),
        .W_Data(W_Data), .I_Data(I_Data), .O_Data(O_Data),
        .NOPOut(nop_s), .DataOut(d_s), .OvfOut(ov_s));

    mac_vec_pipeline #(.Signed(1), .Saturate(0)) u_wrap (
        .clk(clk), .reset(reset), .Stall(Stall), .NOPIn(NOPIn), .Mode(Mode),
        .W_Data(W_Data), .I_Data(I_Data), .O_Data(O_Data),
        .NOPOut(nop_w), .DataOut(d_w), .OvfOut(ov_w));

    mac_vec_pipeline #(.Signed(0), .Saturate(1)) u_uns (
        .clk(clk), .reset(reset), .Stall(Stall), .NOPIn(NOPIn), .Mode(Mode),
        .W_Data(W_Data), .I_Data(I_Data), .O_Data(O_Data),
        .NOPOut(nop_u), .DataOut(d_u), .OvfOut(ov_u));

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        logic [15:0] od [3];
        logic        oo [3];
        logic        on [3];
        od = '{d_s, d_w, d_u};
        oo = '{ov_s, ov_w, ov_u};
        on = '{nop_s, nop_w, nop_u};
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s.dout%0d", tag, c), od[c], e.d[c*16 +: 16]);
            chk($sformatf("%s.ovf%0d", tag, c), 16'(oo[c]), 16'(e.ov[c]));
            chk($sformatf("%s.nop%0d", tag, c), 16'(on[c]), 16'(e.nop));
        end
    endtask

    // Reference arithmetic for one accepted beat across all three builds
    function automatic void model_push(input logic nop, input logic [1:0] md,
                                       input logic [31:0] w, input logic [31:0] i,
                                       input logic [15:0] o);
        exp_t        e;
        longint      dot, add, full, hi, lo, v, a, b;
        logic [7:0]  wb, ib;
        bit          sg;
        e = '0;
        for (int c = 0; c < 3; c++) begin
            if (!nop) begin
                sg  = CFG_SGN[c];
                dot = 0;
                for (int k = 0; k < 4; k++) begin
                    wb  = w[k*8 +: 8];
                    ib  = i[k*8 +: 8];
                    a   = sg ? longint'($signed(wb)) : longint'(wb);
                    b   = sg ? longint'($signed(ib)) : longint'(ib);
                    dot = dot + a * b;
                end
                if (md == 2'b01)      add = sg ? longint'($signed(m_dout[c])) : longint'(m_dout[c]);
                else if (md == 2'b10) add = 0;
                else                  add = sg ? longint'($signed(o)) : longint'(o);
                hi   = sg ? 32767 : 65535;
                lo   = sg ? -32768 : 0;
                full = dot + add;
                m_ovf[c] = (full > hi) || (full < lo);
                if (CFG_SAT[c] && full > hi)      v = hi;
                else if (CFG_SAT[c] && full < lo) v = lo;
                else                              v = full;
                m_dout[c] = v[15:0];
            end
            e.d[c*16 +: 16] = m_dout[c];
            e.ov[c]         = m_ovf[c];
        end
        e.nop = nop;
        sbq.push_back(e);
    endfunction

    task automatic step(input logic st, input logic nop, input logic [1:0] md,
                        input logic [31:0] w, input logic [31:0] i, input logic [15:0] o,
                        input string tag);
        Stall  = st;
        NOPIn  = nop;
        Mode   = md;
        W_Data = w;
        I_Data = i;
        O_Data = o;
        if (!st) model_push(nop, md, w, i, o);
        @(posedge clk);
        #1;
        if (st) begin
            check_outputs({tag, ".frozen"}, last_e);
        end else if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end else begin
            last_e = sbq.pop_front();
            check_outputs(tag, last_e);
        end
    endtask

    task automatic do_reset(input string tag);
        exp_t r;
        #2;
        reset = 1'b1;
        #1;
        r = '0;
        r.nop = 1'b1;
        check_outputs({tag, ".async"}, r);
        sbq.delete();
        for (int c = 0; c < 3; c++) begin
            m_dout[c] = '0;
            m_ovf[c]  = 1'b0;
        end
        Stall = 1'b0;
        NOPIn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"}, r);
        reset  = 1'b0;
        last_e = r;
        model_push(1'b1, 2'b00, '0, '0, '0);
        model_push(1'b1, 2'b00, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        #1;
        do_reset("rst0");

        step(0, 0, 2'b00, pk(1, 2, 3, 4), pk(10, 10, 10, 10), 16'd30, "ext130");
        step(0, 1, 2'b00, '0, '0, '0, "nop_a");
        step(0, 1, 2'b00, '0, '0, '0, "nop_b");

        step(0, 0, 2'b10, pk(10, 0, 0, 0), pk(10, 0, 0, 0), 16'hFFFF, "start100");
        step(0, 0, 2'b01, pk(5, 5, 0, 0), pk(5, 5, 0, 0), 16'h1234, "acc150");
        step(0, 1, 2'b01, pk(9, 9, 9, 9), pk(9, 9, 9, 9), '0, "bubble");
        step(0, 0, 2'b01, pk(5, 0, 0, 0), pk(5, 0, 0, 0), '0, "acc175");

        step(0, 0, 2'b00, pk(127, 127, 127, 127), pk(127, 127, 127, 127), 16'd30000, "satpos");
        step(0, 0, 2'b00, pk(8'h80, 8'h80, 8'h80, 8'h80), pk(127, 127, 127, 127), '0, "satneg");
        step(0, 0, 2'b00, pk(255, 255, 255, 255), pk(255, 255, 255, 255), '0, "uns255");
        step(0, 0, 2'b01, pk(1, 1, 1, 1), pk(1, 1, 1, 1), '0, "accsat");
        step(0, 0, 2'b11, pk(2, 0, 0, 0), pk(3, 0, 0, 0), 16'd7, "mode11");

        step(0, 0, 2'b00, pk(1, 0, 0, 0), pk(1, 0, 0, 0), 16'd100, "st_a");
        step(0, 0, 2'b00, pk(2, 0, 0, 0), pk(1, 0, 0, 0), 16'd200, "st_b");
        step(0, 0, 2'b01, pk(3, 0, 0, 0), pk(1, 0, 0, 0), 16'd300, "st_c");
        step(1, 0, 2'b00, pk(9, 9, 9, 9), pk(9, 9, 9, 9), 16'd999, "stall1");
        step(1, 1, 2'b00, pk(9, 9, 9, 9), pk(9, 9, 9, 9), 16'd999, "stall2");
        step(0, 1, 2'b00, '0, '0, '0, "drain_a");
        step(0, 1, 2'b00, '0, '0, '0, "drain_b");
        step(0, 1, 2'b00, '0, '0, '0, "drain_c");

        step(0, 0, 2'b00, pk(7, 7, 7, 7), pk(7, 7, 7, 7), 16'd1, "inflight_a");
        step(0, 0, 2'b01, pk(6, 6, 6, 6), pk(6, 6, 6, 6), 16'd2, "inflight_b");
        do_reset("rst_mid");
        step(0, 0, 2'b01, pk(3, 0, 0, 0), pk(4, 0, 0, 0), 16'd500, "acc_after_rst");
        step(0, 1, 2'b00, '0, '0, '0, "post_a");
        step(0, 1, 2'b00, '0, '0, '0, "post_b");
        step(0, 1, 2'b00, '0, '0, '0, "post_c");

        for (int n = 0; n < 24; n++) begin
            step(($urandom % 6) == 0, ($urandom % 4) == 0, 2'($urandom % 4),
                 $urandom, $urandom, 16'($urandom), $sformatf("rnd%0d", n));
        end
        step(0, 1, 2'b00, '0, '0, '0, "end_a");
        step(0, 1, 2'b00, '0, '0, '0, "end_b");
        step(0, 1, 2'b00, '0, '0, '0, "end_c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_vec_pipeline.md
Name: mac_vec_pipeline

Overview:
- Parametrised successor to the single-lane MAC pipeline: `Lanes` parallel weight×input products reduced to a dot product, then added to a partial sum.
- Partial-sum source is selectable per beat: external `O_Data`, the block's own previous result (local accumulate), or zero (start new accumulation).
- Adds stall support, signed/unsigned arithmetic, saturate/wrap selection and a per-beat overflow flag.
- Sits in the convolution engine PE row, replacing the scalar MAC where filter taps are processed `Lanes` at a time.

Parameters:
- DataInWidth, 8, width of each weight/input element.
- DataOutWidth, 16, width of partial sum in/out.
- Lanes, 4, parallel multipliers; must be ≥1.
- Signed, 1, 1 = all operands and `O_Data` are two's complement; 0 = unsigned.
- Saturate, 1, 1 = clamp result to the `DataOutWidth` range; 0 = wrap (keep the low `DataOutWidth` bits).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Stall  in  1  freeze the entire pipeline this cycle.
- NOPIn  in  1  1 = input beat is a bubble.
- Mode  in  2  00 external addend, 01 accumulate, 10 start accumulation (addend 0), 11 treated as 00.
- W_Data  in  Lanes*DataInWidth  weights; lane k at bits [k*DataInWidth +: DataInWidth].
- I_Data  in  Lanes*DataInWidth  inputs; same packing as `W_Data`.
- O_Data  in  DataOutWidth  external partial sum.
- NOPOut  out  1  1 = `DataOut` is not a new result.
- DataOut  out  DataOutWidth  result.
- OvfOut  out  1  result overflowed (saturated or wrapped); qualified by `!NOPOut`.

Behaviour:
- Reset (async, immediate): all pipeline registers cleared; `DataOut`=0, `OvfOut`=0, `NOPOut`=1, internal valid bits=0.
- Pipeline has 3 stages, fixed latency 3. A non-bubble beat accepted at edge N appears on `DataOut` with `NOPOut`=0 after edge N+2 (visible in cycle N+3). Throughput is one beat per cycle.
- S1: register the `Lanes` products (2*DataInWidth each, signed or unsigned per `Signed`), the `O_Data` addend, `Mode` and valid (=!NOPIn).
- S2: register the product sum. Width SW = 2*DataInWidth + clog2(Lanes) + 1; no loss.
- S3: addend selection:
  - `O_Data` for mode 00/11.
  - Current `DataOut` register for mode 01.
  - 0 for mode 10.
- S3 arithmetic: form a full sum at width max(SW, DataOutWidth)+1. Then saturate or wrap to `DataOutWidth`.
  - Signed range is [-2^(DataOutWidth-1), 2^(DataOutWidth-1)-1]; unsigned range is [0, 2^DataOutWidth-1].
  - Register the result into `DataOut`. `OvfOut`=1 iff the full sum is outside the range.
- Back-to-back mode 01 beats chain correctly: the previous beat's result is already in `DataOut` when the next beat reaches S3.
- Bubbles: a NOP beat travels with valid=0.
  - At S3, `DataOut` and `OvfOut` hold their previous values and `NOPOut`=1.
  - Bubbles never disturb the accumulator, so a mode 01 beat after any number of bubbles adds onto the last valid result.
- Stall=1: no register changes, including valid bits and `DataOut`; the input beat is ignored (the producer holds it). Stall and NOPIn asserted together behave as stall.
- Mode 01 as the first beat after reset accumulates onto 0.
- Reset mid-operation discards all in-flight beats.

Decomposition:
- Shared package (mac_pkg):
  - Mode encodings: MODE_EXT=2'b00, MODE_ACC=2'b01, MODE_START=2'b10.
  - Function for product-sum width.
  - Saturate/wrap function (`Signed`/`Saturate`-aware).
- Sub-module mac_add_tree: registered sum of `Lanes` products, latency 1, with stall enable. This keeps the S2 reduction generic in `Lanes`.

Test Plan:
- Assert reset mid-stream -> `DataOut`=0, `NOPOut`=1, `OvfOut`=0 immediately; after release, the first beat emerges after 3 cycles.
- Mode 00, W={1,2,3,4}, I={10,10,10,10}, O=30 -> 3 cycles later `DataOut`=130, `NOPOut`=0, `OvfOut`=0; then NOP beat -> `DataOut` holds 130, `NOPOut`=1.
- Mode 10 with dot=100, then mode 01 dot=50, NOP, mode 01 dot=25 (back-to-back except the bubble) -> outputs 100, 150, hold (`NOPOut`=1), 175.
- Signed+Saturate, W=127×4, I=127×4, O=30000, mode 00 (sum 94516) -> `DataOut`=32767, `OvfOut`=1. W=-128×4, I=127×4, O=0 -> `DataOut`=-32768, `OvfOut`=1.
- Saturate=0, same 94516 case -> `DataOut`=28980, `OvfOut`=1. Unsigned build, W=255×4, I=255×4 -> `DataOut`=65535 (sat), `OvfOut`=1.
- Stall held 2 cycles with 3 beats in flight -> outputs and `NOPOut` frozen; results emerge in order 2 cycles late with no loss or duplication.
